// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// This block shares the single integer register file write port between NReq
// writeback requesters, such as the ALU, the load unit and the CSR unit.
// Requests use a valid/ready handshake and are granted round-robin. Each
// accepted write is loaded into a one-entry output stage, and that stage
// drives the register file write port.
//
// Parameters
//   XLen       data width
//   NReg       number of architectural registers
//   NReq       number of writeback requesters (2..8)
//   NRegWidth  register address width (derived)
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   req_valid_i   per-requester write request
//   req_addr_i    per-requester destination register
//   req_data_i    per-requester write data
//   req_ready_o   per-requester accept (combinational from req_valid_i)
//   hold_i        freeze the write port; the output stage is not drained
//   we3_o         register file write enable
//   a3_o          register file write address
//   wd3_o         register file write data
//   pend_valid_o  output stage holds an uncommitted write
//   pend_addr_o   destination of the pending write, for hazard checks
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLen = 32,
    parameter int NReg = 32,
    parameter int NReq = 3,
    localparam int NRegWidth = $clog2(NReg)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NReq-1:0]                     req_valid_i,
    input  logic [NReq-1:0][NRegWidth-1:0]      req_addr_i,
    input  logic [NReq-1:0][XLen-1:0]           req_data_i,
    output logic [NReq-1:0]                     req_ready_o,
    input  logic                                hold_i,
    output logic                                we3_o,
    output logic [NRegWidth-1:0]                a3_o,
    output logic [XLen-1:0]                     wd3_o,
    output logic                                pend_valid_o,
    output logic [NRegWidth-1:0]                pend_addr_o
);

    localparam int PtrW = $clog2(NReq);

    // Requester index reached by stepping 'step' places from 'base', wrapping
    // modulo NReq.
    function automatic logic [PtrW-1:0] rr_index(
        input logic [PtrW-1:0] base,
        input int unsigned     step
    );
        int unsigned sum;
        sum = int'(base) + step;
        if (sum >= NReq) begin
            sum = sum - NReq;
        end else begin
            sum = sum;
        end
        return PtrW'(sum);
    endfunction

    // Pointer value that follows a grant to 'idx'; a grant to the last
    // requester wraps the pointer back to requester 0.
    function automatic logic [PtrW-1:0] rr_next(input logic [PtrW-1:0] idx);
        logic [PtrW-1:0] nxt;
        if (int'(idx) == NReq - 1) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = idx + {{(PtrW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    logic                  r_out_valid;
    logic [NRegWidth-1:0]  r_out_addr;
    logic [XLen-1:0]       r_out_data;
    logic [PtrW-1:0]       r_ptr;

    logic [NReq-1:0]       w_grant;
    logic [PtrW-1:0]       w_gnt_idx;
    logic                  w_gnt_found;
    logic                  w_can_accept;
    logic                  w_drain;
    logic                  w_handshake;
    logic [NRegWidth-1:0]  w_sel_addr;
    logic [XLen-1:0]       w_sel_data;

    // Round-robin search: the first valid requester at or after the pointer
    // wins. At most one grant is raised.
    always_comb begin
        w_grant     = {NReq{1'b0}};
        w_gnt_idx   = {PtrW{1'b0}};
        w_gnt_found = 1'b0;
        for (int unsigned k = 0; k < NReq; k++) begin
            if (!w_gnt_found && req_valid_i[rr_index(r_ptr, k)]) begin
                w_gnt_found                    = 1'b1;
                w_gnt_idx                      = rr_index(r_ptr, k);
                w_grant[rr_index(r_ptr, k)]    = 1'b1;
            end else begin
                w_gnt_found = w_gnt_found;
            end
        end
    end

    // A full stage can only take a new entry if it drains on the same edge.
    // Ready is forced low while reset is asserted, even though the stage is
    // already empty then.
    always_comb begin
        w_drain      = r_out_valid && !hold_i;
        w_can_accept = !r_out_valid || !hold_i;
        if (rst_ni) begin
            req_ready_o = w_grant & {NReq{w_can_accept}};
        end else begin
            req_ready_o = {NReq{1'b0}};
        end
        w_handshake = |req_ready_o;
        w_sel_addr  = req_addr_i[w_gnt_idx];
        w_sel_data  = req_data_i[w_gnt_idx];
    end

    // Output stage and round-robin pointer. A write to x0 completes the
    // handshake but leaves the stage empty, so x0 is never written. A new
    // entry replaces one that drains on the same edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= {NRegWidth{1'b0}};
            r_out_data  <= {XLen{1'b0}};
            r_ptr       <= {PtrW{1'b0}};
        end else if (w_handshake) begin
            r_ptr <= rr_next(w_gnt_idx);
            if (w_sel_addr != {NRegWidth{1'b0}}) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= w_sel_addr;
                r_out_data  <= w_sel_data;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Register file write port and hazard-visible pending entry.
    always_comb begin
        we3_o        = w_drain;
        a3_o         = r_out_addr;
        wd3_o        = r_out_data;
        pend_valid_o = r_out_valid;
        pend_addr_o  = r_out_addr;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_arbiter (NReq = 3). A table of directed vectors
// applies one vector per cycle and checks the outputs against hand-computed
// values. Hand-written sequences then cover reset during a pending write.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int XLen = 32;
    localparam int NReg = 32;
    localparam int NReq = 3;
    localparam int AW   = 5;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NReq-1:0]           req_valid;
    logic [NReq-1:0][AW-1:0]   req_addr;
    logic [NReq-1:0][XLen-1:0] req_data;
    logic [NReq-1:0]           req_ready;
    logic                      hold;
    logic                      we3;
    logic [AW-1:0]             a3;
    logic [XLen-1:0]           wd3;
    logic                      pend_valid;
    logic [AW-1:0]             pend_addr;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLen(XLen), .NReg(NReg), .NReq(NReq)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .hold_i       (hold),
        .we3_o        (we3),
        .a3_o         (a3),
        .wd3_o        (wd3),
        .pend_valid_o (pend_valid),
        .pend_addr_o  (pend_addr)
    );

    typedef struct {
        logic [2:0]       v;
        logic             hold;
        logic [2:0][4:0]  a;
        logic [2:0][31:0] d;
        logic [2:0]       rdy;
        logic             we;
        logic [4:0]       a3;
        logic [31:0]      wd;
        logic             pv;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(
        input logic [2:0] v, input logic hd,
        input logic [4:0] a0, input logic [31:0] d0,
        input logic [4:0] a1, input logic [31:0] d1,
        input logic [4:0] a2, input logic [31:0] d2,
        input logic [2:0] rdy, input logic we,
        input logic [4:0] ea3, input logic [31:0] ewd, input logic pv
    );
        vec_t t;
        t.v = v; t.hold = hd;
        t.a[0] = a0; t.a[1] = a1; t.a[2] = a2;
        t.d[0] = d0; t.d[1] = d1; t.d[2] = d2;
        t.rdy = rdy; t.we = we; t.a3 = ea3; t.wd = ewd; t.pv = pv;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        req_valid = t.v;
        hold      = t.hold;
        req_addr  = t.a;
        req_data  = t.d;
    endtask

    // Address and data are only meaningful while the stage holds a write.
    task automatic check(input string name, input logic [2:0] rdy, input logic we,
                         input logic [4:0] ea3, input logic [31:0] ewd, input logic pv);
        n_vec++;
        if (req_ready !== rdy) begin
            n_err++;
            $display("FAIL %s ready: got %b expected %b", name, req_ready, rdy);
        end
        if (we3 !== we) begin
            n_err++;
            $display("FAIL %s we3: got %b expected %b", name, we3, we);
        end
        if (pend_valid !== pv) begin
            n_err++;
            $display("FAIL %s pend_valid: got %b expected %b", name, pend_valid, pv);
        end
        if (pv) begin
            if (a3 !== ea3 || pend_addr !== ea3) begin
                n_err++;
                $display("FAIL %s a3/pend_addr: got %0d/%0d expected %0d", name, a3, pend_addr, ea3);
            end
            if (wd3 !== ewd) begin
                n_err++;
                $display("FAIL %s wd3: got %h expected %h", name, wd3, ewd);
            end
        end
    endtask

    localparam logic [31:0] D1 = 32'hA1A1_0001;
    localparam logic [31:0] D2 = 32'hB2B2_0002;
    localparam logic [31:0] D3 = 32'hC3C3_0003;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        vec_t t;
        rst_n = 1'b0; hold = 1'b0;
        req_valid = 3'b111;
        req_addr = '0; req_data = '0;

        // Round-robin with all three valid after reset: commits 1,2,3,1,2.
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b001, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b010, 1'b1, 5'd1, D1, 1'b1));
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b100, 1'b1, 5'd2, D2, 1'b1));
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b001, 1'b1, 5'd3, D3, 1'b1));
        vecs.push_back(mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b010, 1'b1, 5'd1, D1, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd2, D2, 1'b1));
        // Wrap: ptr = 2, only req0 valid -> req0 granted, ptr becomes 1.
        vecs.push_back(mk(3'b001, 1'b0, 5'd5, DB, 5'd0, 32'd0, 5'd0, 32'd0, 3'b001, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd5, DB, 1'b1));
        vecs.push_back(mk(3'b011, 1'b0, 5'd4, 32'h44, 5'd6, 32'h66, 5'd0, 32'd0, 3'b010, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b001, 1'b0, 5'd4, 32'h44, 5'd0, 32'd0, 5'd0, 32'd0, 3'b001, 1'b1, 5'd6, 32'h66, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd4, 32'h44, 1'b1));
        // x0 write: accepted and discarded.
        vecs.push_back(mk(3'b010, 1'b0, 5'd0, 32'd0, 5'd0, 32'h1234, 5'd0, 32'd0, 3'b010, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 5'd0, 32'd0, 1'b0));
        // Hold with full stage for 3 cycles, then release with accept.
        vecs.push_back(mk(3'b001, 1'b0, 5'd7, 32'h11, 5'd0, 32'd0, 5'd0, 32'd0, 3'b001, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b010, 1'b1, 5'd0, 32'd0, 5'd9, 32'h99, 5'd0, 32'd0, 3'b000, 1'b0, 5'd7, 32'h11, 1'b1));
        vecs.push_back(mk(3'b010, 1'b1, 5'd0, 32'd0, 5'd9, 32'h99, 5'd0, 32'd0, 3'b000, 1'b0, 5'd7, 32'h11, 1'b1));
        vecs.push_back(mk(3'b010, 1'b1, 5'd0, 32'd0, 5'd9, 32'h99, 5'd0, 32'd0, 3'b000, 1'b0, 5'd7, 32'h11, 1'b1));
        vecs.push_back(mk(3'b010, 1'b0, 5'd0, 32'd0, 5'd9, 32'h99, 5'd0, 32'd0, 3'b010, 1'b1, 5'd7, 32'h11, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd9, 32'h99, 1'b1));
        // Hold with empty stage: one request still accepted, then waits.
        vecs.push_back(mk(3'b100, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 32'hAA, 3'b100, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b000, 1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b0, 5'd10, 32'hAA, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd10, 32'hAA, 1'b1));
        // Back-to-back writes from a lone requester.
        vecs.push_back(mk(3'b001, 1'b0, 5'd12, 32'hC0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b001, 1'b0, 5'd0, 32'd0, 1'b0));
        vecs.push_back(mk(3'b001, 1'b0, 5'd13, 32'hC1, 5'd0, 32'd0, 5'd0, 32'd0, 3'b001, 1'b1, 5'd12, 32'hC0, 1'b1));
        vecs.push_back(mk(3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 3'b000, 1'b1, 5'd13, 32'hC1, 1'b1));

        // Reset state, with requests asserted.
        #1;
        check("reset_state", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].pv);
            @(negedge clk);
        end

        // Reset while a write is pending (ptr = 1 here).
        t = mk(3'b010, 1'b0, 5'd0, 32'd0, 5'd3, 32'h33, 5'd0, 32'd0, 3'b010, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(t);
        #1;
        check("rst_seq_accept", 3'b010, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        check("rst_seq_pending", 3'b000, 1'b1, 5'd3, 32'h33, 1'b1);
        t = mk(3'b111, 1'b0, 5'd1, D1, 5'd2, D2, 5'd3, D3, 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
        drive(t);
        rst_n = 1'b0;
        #1;
        check("rst_seq_async", 3'b000, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_seq_first_grant", 3'b001, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        check("rst_seq_commit", 3'b000, 1'b1, 5'd1, D1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
